xbar_prio_sched: RTL

// Starvation-aware priority scheduler for the TCDM full crossbar when it runs with external

---
 rtl/xbar_prio_sched.sv | 110 +++++++++++
 1 files changed

// File: rtl/xbar_prio_sched.sv
// Starvation-aware priority scheduler for a TCDM crossbar with external arbiter priority.
// Ages losing masters and steers each target's round-robin pointer toward its oldest loser.
module xbar_prio_sched #(
  parameter int unsigned NumIn        = 4,
  parameter int unsigned NumOut       = 4,
  parameter int unsigned CntWidth     = 4,
  parameter int unsigned StarveThresh = 8,
  localparam int unsigned AddW = (NumOut > 1) ? $clog2(NumOut) : 1,
  localparam int unsigned RrW  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumIn-1:0]                 req_i,
  input  logic [NumIn-1:0][AddW-1:0]       add_i,
  input  logic [NumIn-1:0]                 gnt_i,
  output logic [NumOut-1:0][RrW-1:0]       rr_o,
  output logic [NumIn-1:0]                 starve_o
);

  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0] Thresh = CntWidth'(StarveThresh);

  logic [NumIn-1:0][CntWidth-1:0] wait_q, wait_d;
  logic [NumIn-1:0]               starve_q, starve_d;

  // Saturating per-master wait counters; any grant or idle cycle clears them.
  always_comb begin : wait_next
    wait_d   = '0;
    starve_d = '0;
    for (int unsigned j = 0; j < NumIn; j++) begin
      if (req_i[j] && !gnt_i[j]) begin
        wait_d[j] = (wait_q[j] == CntMax) ? CntMax : wait_q[j] + CntWidth'(1);
      end
      starve_d[j] = (wait_d[j] >= Thresh);
    end
  end

  always_ff @(posedge clk_i) begin : wait_reg
    if (rst_i) begin
      wait_q   <= '0;
      starve_q <= '0;
    end else begin
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  assign starve_o = starve_q;

  if (NumIn > 1) begin : g_rr
    logic [NumOut-1:0][RrW-1:0] rr_q, rr_d;

    // Per target: oldest loser wins (cyclic tie-break from the current pointer),
    // otherwise advance past the highest granted master, otherwise hold.
    always_comb begin : rr_next
      logic                found;
      logic                gnt_seen;
      logic [CntWidth-1:0] best_w;
      int unsigned         best_j;
      int unsigned         best_pos;
      int unsigned         pos;
      int unsigned         last_g;
      rr_d = rr_q;
      for (int unsigned k = 0; k < NumOut; k++) begin
        found    = 1'b0;
        gnt_seen = 1'b0;
        best_w   = '0;
        best_j   = 0;
        best_pos = 0;
        pos      = 0;
        last_g   = 0;
        for (int unsigned j = 0; j < NumIn; j++) begin
          if (req_i[j] && (add_i[j] == AddW'(k))) begin
            if (gnt_i[j]) begin
              gnt_seen = 1'b1;
              last_g   = j;
            end else begin
              pos = (j >= 32'(rr_q[k])) ? j - 32'(rr_q[k]) : j + NumIn - 32'(rr_q[k]);
              if (!found || (wait_d[j] > best_w) ||
                  ((wait_d[j] == best_w) && (pos < best_pos))) begin
                found    = 1'b1;
                best_j   = j;
                best_w   = wait_d[j];
                best_pos = pos;
              end
            end
          end
        end
        if (found) begin
          rr_d[k] = RrW'(best_j);
        end else if (gnt_seen) begin
          rr_d[k] = (last_g == NumIn - 1) ? '0 : RrW'(last_g + 1);
        end
      end
    end

    always_ff @(posedge clk_i) begin : rr_reg
      if (rst_i) begin
        rr_q <= '0;
      end else begin
        rr_q <= rr_d;
      end
    end

    assign rr_o = rr_q;
  end else begin : g_rr_tie
    assign rr_o = '0;
  end

endmodule
